// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM state type for the mux scan sequencer.
package mux_scan_pkg;

    localparam int NUM_CH      = 4;  // channels scanned per word
    localparam int SEL_W       = 2;  // width of the mux select lines
    localparam int DWELL_W_DEF = 3;  // default width of the settle-count input

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer for an asynchronous pad input followed by a
// rising-edge detector. The edge history flop is held high until the
// synchronizer carries genuine post-reset samples, so a level that is
// already high when reset releases is never reported as an edge.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;

    // Synchronizer chain, fill tracker and edge history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b1;
            fill_q <= 2'b00;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            fill_q <= {fill_q[0], 1'b1};
            prev_q <= fill_q[1] ? sync_q : 1'b1;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the select lines of an external 4:1 mux, waits a programmable
// settle time on each channel, samples the mux output and presents the
// assembled word on a valid/ready interface with a sticky overrun flag.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int NUM_CH  = mux_scan_pkg::NUM_CH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic [SEL_W-1:0]   sel_out,
    output logic [NUM_CH-1:0]  data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               busy,
    output logic               overrun
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

    state_t              state_q,  state_d;
    logic [SEL_W-1:0]    idx_q,    idx_d;
    logic [DWELL_W-1:0]  cnt_q,    cnt_d;
    logic [DWELL_W-1:0]  dwell_q,  dwell_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   data_q,   data_d;
    logic                valid_q,  valid_d;
    logic                ovr_q,    ovr_d;
    logic                trig;

    sync_rise_det u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (start),
        .rise_o  (trig)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state logic: scan sequencing, word hand-off and overrun tracking
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        // A consumed word frees the output; DONE below may refill it the same cycle
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    idx_d   = '0;
                    cnt_d   = dwell;
                    dwell_d = dwell;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            ST_SAMPLE: begin
                shadow_d[idx_q] = y_in;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + SEL_W'(1);
                    cnt_d   = dwell_q;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (!valid_q || data_ready) begin
                    data_d  = shadow_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                // Select wraps back to channel 0 only here
                idx_d = '0;
                if (cont) begin
                    cnt_d   = dwell;
                    dwell_d = dwell;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel_out    = idx_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: table-driven single scans
// plus directed sequences for overrun, same-cycle reload, ignored start
// edges, mid-scan reset and start held through reset.
module tb_mux_scan_sequencer;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cont;
    logic [DW-1:0] dwell;
    logic          y_in;
    logic [1:0]    sel_out;
    logic [3:0]    data_out;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic          overrun;
    logic [3:0]    pattern;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] dwell;
        logic [3:0]    pattern;
        logic [3:0]    exp_data;
        int            exp_lat;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    // Model of the downstream 4:1 mux
    assign y_in = pattern[sel_out];

    mux_scan_sequencer #(.DWELL_W(DW), .NUM_CH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .dwell      (dwell),
        .y_in       (y_in),
        .sel_out    (sel_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        data_ready = 1'b0;
        dwell      = '0;
        pattern    = 4'h0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    // Ticks until busy is seen; n = ticks taken, or max+1 on timeout
    task automatic wait_busy(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (busy) begin
                n = i;
                break;
            end
        end
    endtask

    // Ticks until data_valid is seen; n = ticks taken, or max+1 on timeout
    task automatic wait_valid(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (data_valid) begin
                n = i;
                break;
            end
        end
    endtask

    // One complete scan with data_ready held high, checked against a table row
    task automatic run_row(input int r);
        int  n;
        int  c;
        int  per;
        int  exp_sel;
        bit  sel_ok;
        do_reset();
        dwell      = vecs[r].dwell;
        pattern    = vecs[r].pattern;
        data_ready = 1'b1;
        start      = 1'b1;
        wait_busy(10, n);
        start = 1'b0;
        check($sformatf("row%0d start_to_busy", r), n, 3);
        per    = int'(vecs[r].dwell) + 2;
        c      = 0;
        sel_ok = 1'b1;
        while (!data_valid && c < 200) begin
            exp_sel = (c < 4 * per) ? (c / per) : 3;
            if (sel_out !== 2'(exp_sel)) sel_ok = 1'b0;
            tick();
            c++;
        end
        check($sformatf("row%0d latency", r), c, vecs[r].exp_lat);
        check($sformatf("row%0d data", r), data_out, vecs[r].exp_data);
        check($sformatf("row%0d sel_sequence_ok", r), sel_ok, 1);
        check($sformatf("row%0d busy_after", r), busy, 0);
        tick();
        check($sformatf("row%0d valid_one_cycle", r), data_valid, 0);
        check($sformatf("row%0d overrun", r), overrun, 0);
    endtask

    initial begin
        int  n;
        bit  saw;

        vecs[0] = '{dwell: 3'd0, pattern: 4'b1010, exp_data: 4'b1010, exp_lat: 9};
        vecs[1] = '{dwell: 3'd5, pattern: 4'b0110, exp_data: 4'b0110, exp_lat: 29};
        vecs[2] = '{dwell: 3'd2, pattern: 4'b1101, exp_data: 4'b1101, exp_lat: 17};
        vecs[3] = '{dwell: 3'd7, pattern: 4'b0001, exp_data: 4'b0001, exp_lat: 37};
        vecs[4] = '{dwell: 3'd3, pattern: 4'b1111, exp_data: 4'b1111, exp_lat: 21};

        // Reset values
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; data_ready = 1'b0;
        dwell = '0; pattern = 4'h0;
        #1;
        check("rst sel_out", sel_out, 0);
        check("rst data_out", data_out, 0);
        check("rst data_valid", data_valid, 0);
        check("rst busy", busy, 0);
        check("rst overrun", overrun, 0);

        for (int r = 0; r < 5; r++) run_row(r);

        // Overrun: consumer stalled while scanning continuously
        do_reset();
        dwell = 3'd0; cont = 1'b1; pattern = 4'b1010;
        start = 1'b1; wait_busy(10, n); start = 1'b0;
        wait_valid(20, n);
        check("ovr first_latency", n, 9);
        check("ovr first_data", data_out, 4'b1010);
        check("ovr clear_before", overrun, 0);
        pattern = 4'b0101;
        repeat (9) tick();
        check("ovr set", overrun, 1);
        check("ovr data_held", data_out, 4'b1010);
        check("ovr valid_held", data_valid, 1);
        cont = 1'b0; data_ready = 1'b1;
        tick();
        check("ovr valid_after_transfer", data_valid, 0);
        check("ovr sticky", overrun, 1);
        wait_valid(20, n);
        check("ovr third_latency", n, 8);
        check("ovr third_data", data_out, 4'b0101);
        check("ovr still_sticky", overrun, 1);
        tick();
        check("ovr busy_end", busy, 0);

        // Ready asserted exactly in the DONE cycle: word replaced, valid stays high
        do_reset();
        dwell = 3'd0; cont = 1'b1; pattern = 4'b1010;
        start = 1'b1; wait_busy(10, n); start = 1'b0;
        wait_valid(20, n);
        check("hs first_latency", n, 9);
        pattern = 4'b0011;
        repeat (8) tick();
        check("hs done_sel", sel_out, 3);
        check("hs data_before", data_out, 4'b1010);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        cont = 1'b0;
        check("hs valid_stays", data_valid, 1);
        check("hs new_data", data_out, 4'b0011);
        check("hs no_overrun", overrun, 0);

        // Second start edge during a scan is ignored
        do_reset();
        dwell = 3'd1; data_ready = 1'b1; pattern = 4'b1100;
        start = 1'b1; wait_busy(10, n); start = 1'b0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        wait_valid(30, n);
        check("ign latency", n, 11);
        check("ign data", data_out, 4'b1100);
        saw = 1'b0;
        repeat (15) begin
            tick();
            if (busy || data_valid) saw = 1'b1;
        end
        check("ign no_rescan", saw, 0);

        // Reset in the middle of channel 2, start left high through reset
        do_reset();
        dwell = 3'd1; data_ready = 1'b1; pattern = 4'b1100;
        start = 1'b1; wait_busy(10, n); start = 1'b0;
        tick(); start = 1'b1;
        n = 0;
        while (sel_out != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        check("mrst reached_ch2", (n < 20), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst busy", busy, 0);
        check("mrst sel_out", sel_out, 0);
        check("mrst data_out", data_out, 0);
        check("mrst data_valid", data_valid, 0);
        check("mrst overrun", overrun, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            tick();
            if (busy || data_valid) saw = 1'b1;
        end
        check("held_start no_scan", saw, 0);

        // A fresh 0->1 edge after reset starts a scan three cycles later
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        wait_busy(10, n);
        start = 1'b0;
        check("fresh start_to_busy", n, 3);
        wait_valid(30, n);
        check("fresh latency", n, 13);
        check("fresh data", data_out, 4'b1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
